// File: rtl/serial_subtractor_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor_if
// Handshake/operand bundle for the bit-serial subtractor.
//   start      : request, honoured only while the unit is not busy
//   A, B, bin  : minuend, subtrahend, borrow-in (captured on accepted start)
//   D, bout    : difference and unsigned borrow-out (valid from done onward)
//   busy, done : operation in progress / one-cycle completion pulse
//   ovf        : signed overflow flag, present only with SERIAL_SUB_OVERFLOW_EN
// Modports: master drives the request side, slave is the subtractor.
// ----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin;
    logic [WIDTH-1:0] D;
    logic             bout;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf;
`endif

    modport master (
        output start, A, B, bin,
`ifdef SERIAL_SUB_OVERFLOW_EN
        input  ovf,
`endif
        input  D, bout, busy, done
    );

    modport slave (
        input  start, A, B, bin,
`ifdef SERIAL_SUB_OVERFLOW_EN
        output ovf,
`endif
        output D, bout, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor: D = A - B - bin (mod 2^WIDTH), LSB first, one bit
// per clock through a single difference cell and one borrow flip-flop.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : serial_subtractor_if.slave (start, A, B, bin -> D, bout, busy, done)
//
// Timing: start accepted at edge k; bits processed on edges k+1..k+WIDTH;
// D/bout/done update at edge k+WIDTH+1. A start presented during the done
// cycle is accepted immediately (back-to-back).
//
// Optional feature: define SERIAL_SUB_OVERFLOW_EN to add the ovf output,
// the signed two's-complement overflow of A - B - bin.
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic             borrow_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] d_r;
    logic             bout_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic             diff_s;
    logic             borrow_next_s;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb_r;
    logic             b_msb_r;
    logic             ovf_r;
`endif

    // Full-subtractor difference bit.
    function automatic logic sub_diff(input logic a, input logic b, input logic br);
        return a ^ b ^ br;
    endfunction

    // Full-subtractor borrow: borrow when a < b + br at this bit position.
    function automatic logic sub_borrow(input logic a, input logic b, input logic br);
        return (~a & b) | (~(a ^ b) & br);
    endfunction

    // Accept logic and the one-bit difference cell.
    always_comb begin
        accept_s      = 1'b0;
        diff_s        = sub_diff(a_sh_r[0], b_sh_r[0], borrow_r);
        borrow_next_s = sub_borrow(a_sh_r[0], b_sh_r[0], borrow_r);
        if (state_r != RUN) begin
            accept_s = bus.start;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Control FSM, operand/result shifters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_r    <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            d_r      <= {WIDTH{1'b0}};
            bout_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
            ovf_r    <= 1'b0;
`endif
        end else if (accept_s) begin
            // Accepted from IDLE or straight out of DONE.
            state_r  <= RUN;
            a_sh_r   <= bus.A;
            b_sh_r   <= bus.B;
            res_r    <= {WIDTH{1'b0}};
            borrow_r <= bus.bin;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_r  <= bus.A[WIDTH-1];
            b_msb_r  <= bus.B[WIDTH-1];
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                end
                RUN: begin
                    if (cnt_r == LAST_CNT) begin
                        // All bits shifted: publish result on this edge.
                        d_r     <= res_r;
                        bout_r  <= borrow_r;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        ovf_r   <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ res_r[WIDTH-1]);
`endif
                    end else begin
                        res_r    <= {diff_s, res_r[WIDTH-1:1]};
                        a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                        b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                        borrow_r <= borrow_next_s;
                        cnt_r    <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.D    = d_r;
    assign bus.bout = bout_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign bus.ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
// Scoreboard bench: the driver pushes the arithmetic expectation (and the
// accept edge) for every accepted start; an independent monitor checks each
// done pulse, the latency, busy, and that D/bout hold between results.
// ----------------------------------------------------------------------------
module tb_serial_subtractor;
    localparam int W = 5;

    typedef struct {
        int d;
        int bout;
        int ovf;
        int k;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   miscompares;
    exp_t q[$];
    int   last_d;
    int   last_b;
    int   last_o;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input int a, input int b, input int bi, input int k);
        exp_t r;
        int   sa;
        int   sb;
        int   sd;
        r.d    = ((a - b - bi) % 32 + 32) % 32;
        r.bout = (a < b + bi) ? 1 : 0;
        sa     = (a >= 16) ? a - 32 : a;
        sb     = (b >= 16) ? b - 32 : b;
        sd     = sa - sb - bi;
        r.ovf  = (sd < -16 || sd > 15) ? 1 : 0;
        r.k    = k;
        return r;
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        int   exp_busy;
        last_d = 0;
        last_b = 0;
        last_o = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                last_d = 0;
                last_b = 0;
                last_o = 0;
            end else if (bus.done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("latency", cyc, e.k + W + 1);
                    check("D", int'(bus.D), e.d);
                    check("bout", int'(bus.bout), e.bout);
                    check("busy_at_done", int'(bus.busy), 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
                    check("ovf", int'(bus.ovf), e.ovf);
                    last_o = e.ovf;
`endif
                    last_d = e.d;
                    last_b = e.bout;
                end
            end else begin
                exp_busy = 0;
                if (q.size() != 0) begin
                    if (cyc >= q[0].k && cyc <= q[0].k + W) exp_busy = 1;
                end
                check("busy", int'(bus.busy), exp_busy);
                check("D_hold", int'(bus.D), last_d);
                check("bout_hold", int'(bus.bout), last_b);
`ifdef SERIAL_SUB_OVERFLOW_EN
                check("ovf_hold", int'(bus.ovf), last_o);
`endif
            end
        end
    end

    // Wait for done, scribbling ignored starts and operands meanwhile.
    task automatic wait_done();
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.done) break;
            n++;
            if (n > W + 3) begin
                check("done_timeout", 0, 1);
                break;
            end
            bus.start = 1'($urandom_range(0, 1));
            bus.A     = W'($urandom_range(0, 31));
            bus.B     = W'($urandom_range(0, 31));
            bus.bin   = 1'($urandom_range(0, 1));
        end
    endtask

    // Issue one operation at the current falling edge and wait for its result.
    task automatic do_op(input int a, input int b, input int bi);
        bus.start = 1'b1;
        bus.A     = W'(a);
        bus.B     = W'(b);
        bus.bin   = 1'(bi);
        q.push_back(model(a, b, bi, cyc + 1));
        wait_done();
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.A       = '0;
        bus.B       = '0;
        bus.bin     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_D", int'(bus.D), 0);
        check("rst_bout", int'(bus.bout), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        rst = 1'b0;
        idle(2);

        // Directed cases.
        do_op(13, 6, 0);  idle(2);
        do_op(6, 13, 0);  idle(1);
        do_op(0, 0, 1);   idle(1);
        do_op(31, 31, 0); idle(2);
        do_op(20, 3, 0);                 // ignored starts injected while busy
        do_op(9, 4, 0);   idle(2);       // back-to-back from the done cycle
        do_op(16, 1, 0);  idle(1);
        do_op(3, 1, 0);   idle(2);
        do_op(0, 16, 1);  idle(1);

        // Reset in the middle of a run: abort, no done pulse.
        bus.start = 1'b1;
        bus.A     = W'(20);
        bus.B     = W'(3);
        bus.bin   = 1'b0;
        q.push_back(model(20, 3, 0, cyc + 1));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_D", int'(bus.D), 0);
        check("abort_bout", int'(bus.bout), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(W + 3);
        do_op(13, 6, 0);  idle(1);

        // Randomized operations, some back-to-back.
        for (int i = 0; i < 60; i++) begin
            do_op($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) idle($urandom_range(1, 3));
        end
        idle(W + 4);
        check("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
